route_filter: RTL and testbench

//  Stage directly downstream of the VSID parser in the NMU ingress parse chain.

---
 rtl/nmu_filter_pkg.sv | 21 ++
 rtl/filter_beat_fifo.sv | 49 ++++
 rtl/route_filter.sv | 168 ++++++++++++++++
 tb/tb_route_filter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmu_filter_pkg.sv
// Shared types and helpers for the NMU ingress route filter.
package nmu_filter_pkg;

    typedef enum logic [1:0] {
        S_HEAD = 2'd0,
        S_BODY = 2'd1,
        S_WAIT = 2'd2
    } filter_state_t;

    // Routing is always decided within this many header bytes.
    localparam int MIN_HEAD_BYTES = 120;

    function automatic int min_head_beats(input int bus_bytes);
        return (MIN_HEAD_BYTES + bus_bytes - 1) / bus_bytes;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/filter_beat_fifo.sv
// First-word-fall-through beat FIFO for the route filter.
// rd_data always shows the oldest entry; full/empty are exact.
module filter_beat_fifo #(
    parameter int WIDTH = 73,
    parameter int DEPTH = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/route_filter.sv
// Buffers packet heads until the route decision, then forwards with tdest or drops.
// Optional ROUTE_FILTER_DROP_COUNT_EN adds saturating drop/overflow counters.
module route_filter
    import nmu_filter_pkg::*;
#(
    parameter int AXIS_BUS_WIDTH = 64,
    parameter int AXIS_ID_WIDTH  = 4,
    parameter int BUFFER_DEPTH   = 32,
    localparam int NUM_BUS_BYTES = AXIS_BUS_WIDTH / 8,
    localparam int NUM_AXIS_ID   = 2 ** AXIS_ID_WIDTH
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
    input  logic [NUM_BUS_BYTES-1:0]  axis_in_tkeep,
    input  logic                      axis_in_tlast,
    input  logic                      axis_in_tvalid,
    output logic                      axis_in_tready,
    input  logic [NUM_AXIS_ID-1:0]    route_mask_in,
    input  logic                      poisoned_in,
    input  logic                      parsing_done_in,
    input  logic                      parsing_vsid_done_in,
    output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
    output logic [NUM_BUS_BYTES-1:0]  axis_out_tkeep,
    output logic                      axis_out_tlast,
    output logic                      axis_out_tvalid,
    output logic [NUM_AXIS_ID-1:0]    axis_out_tdest,
    input  logic                      axis_out_tready
`ifdef ROUTE_FILTER_DROP_COUNT_EN
    ,
    output logic [31:0]               drop_count,
    output logic [31:0]               overflow_count
`endif
);

    localparam int BEAT_W = AXIS_BUS_WIDTH + NUM_BUS_BYTES + 1;

    generate
        if (BUFFER_DEPTH < min_head_beats(NUM_BUS_BYTES) ||
            (BUFFER_DEPTH & (BUFFER_DEPTH - 1)) != 0) begin : g_depth_check
            $error("route_filter: BUFFER_DEPTH must be a power of 2 covering MIN_HEAD_BYTES");
        end
    endgenerate

    filter_state_t            state;
    filter_state_t            state_nxt;
    logic                     dec_valid;
    logic [NUM_AXIS_ID-1:0]   dec_mask;
    logic                     drop_mode;

    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     fifo_wr;
    logic                     fifo_rd;
    logic [BEAT_W-1:0]        fifo_rdata;

    logic                     in_rdy;
    logic                     in_fire;
    logic                     dec_evt;
    logic                     overflow;
    logic                     dec_clr;
    logic                     rd_last;

    assign drop_mode = (dec_mask == '0);

    // Input ready is derived before the FSM so the accept strobe has no loop.
    always_comb begin
        in_rdy = 1'b0;
        case (state)
            S_HEAD:  in_rdy = !fifo_full;
            S_BODY:  in_rdy = drop_mode ? 1'b1 : !fifo_full;
            default: in_rdy = 1'b0;
        endcase
    end

    assign axis_in_tready = aresetn && in_rdy;
    assign in_fire        = axis_in_tvalid && axis_in_tready;

    always_comb begin
        state_nxt = state;
        fifo_wr   = 1'b0;
        dec_evt   = 1'b0;
        overflow  = 1'b0;
        case (state)
            S_HEAD: begin
                fifo_wr = in_fire;
                if (in_fire && ((parsing_done_in && parsing_vsid_done_in) || axis_in_tlast)) begin
                    dec_evt   = 1'b1;
                    state_nxt = axis_in_tlast ? S_WAIT : S_BODY;
                end else if (fifo_full) begin
                    // Head outgrew the buffer without a decision: drop the packet.
                    overflow  = 1'b1;
                    state_nxt = S_BODY;
                end
            end
            S_BODY: begin
                fifo_wr = in_fire && !drop_mode;
                if (in_fire && axis_in_tlast) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!dec_valid) state_nxt = S_HEAD;
            end
            default: state_nxt = S_HEAD;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= S_HEAD;
        else          state <= state_nxt;
    end

    filter_beat_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (BUFFER_DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .wr_en   (fifo_wr),
        .wr_data ({axis_in_tdata, axis_in_tkeep, axis_in_tlast}),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {axis_out_tdata, axis_out_tkeep, axis_out_tlast} = fifo_rdata;
    assign rd_last = fifo_rdata[0];

    assign axis_out_tvalid = aresetn && dec_valid && !drop_mode && !fifo_empty;
    assign axis_out_tdest  = dec_mask;
    assign fifo_rd         = dec_valid && !fifo_empty && (drop_mode || axis_out_tready);

    // A dropped packet's tlast may never reach the FIFO (discarded in S_BODY),
    // so the decision also retires once the input side is done and the FIFO drained.
    assign dec_clr = dec_valid && ((fifo_rd && rd_last) || (state == S_WAIT && fifo_empty));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            dec_valid <= 1'b0;
            dec_mask  <= '0;
        end else if (dec_evt) begin
            dec_valid <= 1'b1;
            dec_mask  <= poisoned_in ? '0 : route_mask_in;
        end else if (overflow) begin
            dec_valid <= 1'b1;
            dec_mask  <= '0;
        end else if (dec_clr) begin
            dec_valid <= 1'b0;
        end
    end

`ifdef ROUTE_FILTER_DROP_COUNT_EN
    logic drop_evt;

    assign drop_evt = overflow || (dec_evt && (poisoned_in || route_mask_in == '0));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            drop_count     <= '0;
            overflow_count <= '0;
        end else begin
            if (drop_evt) drop_count     <= sat_inc(drop_count);
            if (overflow) overflow_count <= sat_inc(overflow_count);
        end
    end
`endif

endmodule

// File: tb/tb_route_filter.sv
// Self-checking bench for route_filter: directed scenarios plus randomized packets
// scored against a packet-level model of the routing decision.
module tb_route_filter;

    localparam int W     = 64;
    localparam int KB    = W / 8;
    localparam int IDW   = 2;
    localparam int NID   = 4;
    localparam int DEPTH = 16;

    logic           aclk = 1'b0;
    logic           aresetn = 1'b0;
    logic [W-1:0]   axis_in_tdata = '0;
    logic [KB-1:0]  axis_in_tkeep = '0;
    logic           axis_in_tlast = 1'b0;
    logic           axis_in_tvalid = 1'b0;
    logic           axis_in_tready;
    logic [NID-1:0] route_mask_in = '0;
    logic           poisoned_in = 1'b0;
    logic           parsing_done_in = 1'b0;
    logic           parsing_vsid_done_in = 1'b0;
    logic [W-1:0]   axis_out_tdata;
    logic [KB-1:0]  axis_out_tkeep;
    logic           axis_out_tlast;
    logic           axis_out_tvalid;
    logic [NID-1:0] axis_out_tdest;
    logic           axis_out_tready = 1'b1;
`ifdef ROUTE_FILTER_DROP_COUNT_EN
    logic [31:0]    drop_count;
    logic [31:0]    overflow_count;
`endif

    always #5 aclk = ~aclk;

    route_filter #(
        .AXIS_BUS_WIDTH (W),
        .AXIS_ID_WIDTH  (IDW),
        .BUFFER_DEPTH   (DEPTH)
    ) dut (
        .aclk                 (aclk),
        .aresetn              (aresetn),
        .axis_in_tdata        (axis_in_tdata),
        .axis_in_tkeep        (axis_in_tkeep),
        .axis_in_tlast        (axis_in_tlast),
        .axis_in_tvalid       (axis_in_tvalid),
        .axis_in_tready       (axis_in_tready),
        .route_mask_in        (route_mask_in),
        .poisoned_in          (poisoned_in),
        .parsing_done_in      (parsing_done_in),
        .parsing_vsid_done_in (parsing_vsid_done_in),
        .axis_out_tdata       (axis_out_tdata),
        .axis_out_tkeep       (axis_out_tkeep),
        .axis_out_tlast       (axis_out_tlast),
        .axis_out_tvalid      (axis_out_tvalid),
        .axis_out_tdest       (axis_out_tdest),
        .axis_out_tready      (axis_out_tready)
`ifdef ROUTE_FILTER_DROP_COUNT_EN
        ,
        .drop_count           (drop_count),
        .overflow_count       (overflow_count)
`endif
    );

    typedef struct packed {
        logic [W-1:0]   d;
        logic [KB-1:0]  k;
        logic           l;
        logic [NID-1:0] dest;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    out_cnt = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    int    stall_log[64];
    int    exp_drop = 0;
    int    exp_ovf = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Output sink readiness, updated just after each active edge.
    initial forever begin
        @(posedge aclk);
        #1;
        case (rdy_mode)
            0:       axis_out_tready = 1'b1;
            1:       axis_out_tready = 1'($urandom_range(0, 1));
            default: axis_out_tready = 1'b0;
        endcase
    end

    // Output monitor: scores every handshake and checks stability while stalled.
    initial begin
        beat_t       e;
        logic        hold_vld = 1'b0;
        beat_t       hold;
        forever begin
            @(negedge aclk);
            if (aresetn && axis_out_tvalid) begin
                if (hold_vld) begin
                    chk("stall_data", axis_out_tdata, hold.d);
                    chk("stall_side", {axis_out_tkeep, axis_out_tlast, axis_out_tdest},
                        {hold.k, hold.l, hold.dest});
                end
                if (axis_out_tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", axis_out_tdata, 64'hDEAD_0000_DEAD_0000 ^ axis_out_tdata ^ 64'h1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_tdata", axis_out_tdata, e.d);
                        chk("out_tkeep", 64'(axis_out_tkeep), 64'(e.k));
                        chk("out_tlast", 64'(axis_out_tlast), 64'(e.l));
                        chk("out_tdest", 64'(axis_out_tdest), 64'(e.dest));
                    end
                    out_cnt++;
                    hold_vld = 1'b0;
                end else begin
                    hold_vld = 1'b1;
                    hold     = '{axis_out_tdata, axis_out_tkeep, axis_out_tlast, axis_out_tdest};
                end
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    // Present one beat (called at posedge+1) and wait until it is accepted.
    task automatic send_beat(input logic [W-1:0] d, input logic [KB-1:0] k, input logic l,
                             input logic fa, input logic fb, input logic [NID-1:0] m,
                             input logic p, output int stalls);
        axis_in_tdata        = d;
        axis_in_tkeep        = k;
        axis_in_tlast        = l;
        parsing_done_in      = fa;
        parsing_vsid_done_in = fb;
        route_mask_in        = m;
        poisoned_in          = p;
        axis_in_tvalid       = 1'b1;
        stalls = 0;
        forever begin
            @(negedge aclk);
            if (axis_in_tready) begin
                @(posedge aclk);
                #1;
                break;
            end
            @(posedge aclk);
            #1;
            stalls++;
            if (stalls > 2000) begin
                checks++;
                errors++;
                $error("FAIL in_accept_timeout: observed tready=0 for %0d cycles expected acceptance", stalls);
                summary_and_finish();
            end
        end
        axis_in_tvalid = 1'b0;
    endtask

    // Builds a packet, derives its fate from the routing rules, then drives it.
    // dk: beat index carrying both done flags (-1 or >= n: none; tlast decides).
    task automatic send_pkt(input int n, input int dk, input logic [NID-1:0] mask,
                            input logic poison, input bit gaps, output int n_exp);
        logic [W-1:0]   dat[64];
        logic [KB-1:0]  kp[64];
        logic           fa[64];
        logic           fb[64];
        logic [NID-1:0] mk[64];
        logic           ps[64];
        logic [NID-1:0] dest;
        int             k;
        int             r;
        int             s;
        for (int i = 0; i < n; i++) begin
            dat[i] = {$urandom(), $urandom()};
            kp[i]  = (i == n - 1) ? KB'($urandom_range(1, 255)) : '1;
            mk[i]  = NID'($urandom_range(0, 15));
            ps[i]  = 1'($urandom_range(0, 1));
            if (dk < 0 || dk >= n || i < dk) begin
                r = $urandom_range(0, 2);
                fa[i] = (r == 1);
                fb[i] = (r == 2);
            end else if (i == dk) begin
                fa[i] = 1'b1;
                fb[i] = 1'b1;
            end else begin
                fa[i] = 1'($urandom_range(0, 1));
                fb[i] = 1'($urandom_range(0, 1));
            end
        end
        if (dk >= 0 && dk < n) begin
            mk[dk] = mask;
            ps[dk] = poison;
        end else begin
            mk[n-1] = mask;
            ps[n-1] = poison;
        end
        // Reference: the first beat with both flags (or the last beat) decides,
        // unless the head does not fit in the buffer.
        k = n - 1;
        for (int i = 0; i < n; i++) begin
            if (fa[i] && fb[i]) begin
                k = i;
                break;
            end
        end
        n_exp = 0;
        if (k >= DEPTH) begin
            exp_drop++;
            exp_ovf++;
        end else begin
            dest = ps[k] ? '0 : mk[k];
            if (dest == '0) begin
                exp_drop++;
            end else begin
                for (int i = 0; i < n; i++) exp_q.push_back('{dat[i], kp[i], (i == n - 1), dest});
                n_exp = n;
            end
        end
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge aclk);
                #1;
            end
            send_beat(dat[i], kp[i], (i == n - 1), fa[i], fb[i], mk[i], ps[i], s);
            stall_log[i] = s;
        end
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge aclk);
            #1;
            t++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
        repeat (DEPTH + 4) @(posedge aclk);
        #1;
    endtask

    task automatic chk_counters(input string tag);
`ifdef ROUTE_FILTER_DROP_COUNT_EN
        chk({tag, "_drop_count"}, 64'(drop_count), 64'(exp_drop));
        chk({tag, "_overflow_count"}, 64'(overflow_count), 64'(exp_ovf));
`else
        chk({tag, "_idle_tvalid"}, 64'(axis_out_tvalid), 64'd0);
`endif
    endtask

    initial begin
        int base;
        int n_exp;
        int sum;
        int n;
        int s;
        logic [W-1:0] d;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_in_tready", 64'(axis_in_tready), 64'd0);
        chk("rst_out_tvalid", 64'(axis_out_tvalid), 64'd0);
        chk("rst_tdest", 64'(axis_out_tdest), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("post_rst_in_tready", 64'(axis_in_tready), 64'd1);
        chk_counters("rst");
        @(posedge aclk);
        #1;

        // 1: 8-beat packet, decision on beat 7
        base = out_cnt;
        send_pkt(8, 6, 4'b0010, 1'b0, 1'b0, n_exp);
        drain("t1_drain");
        chk("t1_beats", 64'(out_cnt - base), 64'd8);

        // 2: poisoned at decision, then a normal packet
        base = out_cnt;
        send_pkt(8, 6, 4'b0010, 1'b1, 1'b0, n_exp);
        drain("t2_drain");
        chk("t2_beats", 64'(out_cnt - base), 64'd0);
        chk_counters("t2");
        base = out_cnt;
        send_pkt(8, 6, 4'b0100, 1'b0, 1'b0, n_exp);
        drain("t2b_drain");
        chk("t2b_beats", 64'(out_cnt - base), 64'd8);

        // 3: decision on tlast only
        base = out_cnt;
        send_pkt(2, -1, 4'b1001, 1'b0, 1'b0, n_exp);
        drain("t3_drain");
        chk("t3_beats", 64'(out_cnt - base), 64'd2);

        // 4: head overflow, done flags first on beat 20
        base = out_cnt;
        send_pkt(24, 19, 4'b0110, 1'b0, 1'b0, n_exp);
        chk("t4_beat17_stall", 64'(stall_log[16]), 64'd1);
        sum = 0;
        for (int i = 17; i < 24; i++) sum += stall_log[i];
        chk("t4_tail_stalls", 64'(sum), 64'd0);
        drain("t4_drain");
        chk("t4_beats", 64'(out_cnt - base), 64'd0);
        chk_counters("t4");
        base = out_cnt;
        send_pkt(6, 2, 4'b0001, 1'b0, 1'b0, n_exp);
        drain("t4b_drain");
        chk("t4b_beats", 64'(out_cnt - base), 64'd6);

        // 5: random backpressure, then randomized packets
        rdy_mode = 1;
        base = out_cnt;
        send_pkt(12, 3, 4'b1010, 1'b0, 1'b1, n_exp);
        drain("t5_drain");
        chk("t5_beats", 64'(out_cnt - base), 64'd12);
        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, 24);
            base = out_cnt;
            send_pkt(n, ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, n + 2),
                     NID'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), 1'b1, n_exp);
            drain("rnd_drain");
            chk("rnd_beats", 64'(out_cnt - base), 64'(n_exp));
        end
        chk_counters("rnd");

        // 6: reset mid-packet with the output stalled
        rdy_mode = 2;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            d = {$urandom(), $urandom()};
            send_beat(d, '1, 1'b0, (i == 1), (i == 1), 4'b0011, 1'b0, s);
        end
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("t6_pre_rst_tvalid", 64'(axis_out_tvalid), 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        exp_q.delete();
        exp_drop = 0;
        exp_ovf = 0;
        @(negedge aclk);
        chk("t6_tvalid", 64'(axis_out_tvalid), 64'd0);
        chk("t6_in_tready", 64'(axis_in_tready), 64'd1);
        chk("t6_tdest", 64'(axis_out_tdest), 64'd0);
        chk_counters("t6");
        rdy_mode = 1;
        @(posedge aclk);
        #1;
        base = out_cnt;
        send_pkt(10, 4, 4'b1100, 1'b0, 1'b0, n_exp);
        drain("t6_drain");
        chk("t6_beats", 64'(out_cnt - base), 64'd10);

        summary_and_finish();
    end

endmodule
